// File: rtl/cam_pkg.sv
// Shared types and constants for the OV7670-style camera transmitter.
// Holds the frame state enum, RGB444 byte-packing constants and the colour-bar table.
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } cam_state_e;

  // Byte 1 of each pixel carries the red nibble under a zero high nibble.
  localparam logic [3:0] BYTE1_PAD = 4'b0000;

  localparam int BAR_COUNT = 8;
  localparam logic [11:0] BAR_RGB [BAR_COUNT] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  function automatic logic [11:0] bar_color(input int unsigned col, input int unsigned h_act);
    int unsigned idx;
    idx = col / (h_act / BAR_COUNT);
    if (idx > BAR_COUNT - 1) idx = BAR_COUNT - 1;
    return BAR_RGB[3'(idx)];
  endfunction

endpackage

// File: rtl/cam_tx_if.sv
// Frame-buffer read port plus camera output bus of cam_tx.
// master = transmitter side, slave = frame buffer / capture side.
interface cam_tx_if #(
  parameter int AW = 15,
  parameter int DW = 12
);
  logic          en;
  logic [AW-1:0] RAM_addr_out;
  logic [DW-1:0] RAM_data_in;
  logic          CAM_vsync;
  logic          CAM_href;
  logic [7:0]    CAM_px_data;
  logic          frame_done;

  modport master (
    input  en, RAM_data_in,
    output RAM_addr_out, CAM_vsync, CAM_href, CAM_px_data, frame_done
  );

  modport slave (
    output en, RAM_data_in,
    input  RAM_addr_out, CAM_vsync, CAM_href, CAM_px_data, frame_done
  );
endinterface

// File: rtl/cam_tx_timing.sv
// Line/frame counters and frame state machine for cam_tx. vsync, href and
// frame_done are registered; ld_byte1/ld_byte2 announce the byte launched at the next edge.
module cam_tx_timing
  import cam_pkg::*;
#(
  parameter int H_ACT       = 160,
  parameter int V_ACT       = 120,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 2,
  parameter int V_FRONT     = 2
) (
  input  logic CAM_pclk,
  input  logic rst,
  input  logic en,
  output logic vsync,
  output logic href,
  output logic frame_done,
  output logic ld_byte1,
  output logic ld_byte2
);

  localparam int L  = 2 * H_ACT + H_BLANK;
  localparam int HW = $clog2(L);
  localparam int VW = $clog2(VSYNC_LINES + V_BACK + V_ACT + V_FRONT);

  cam_state_e    state;
  logic [HW-1:0] h_cnt;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_cnt;
  logic          eol;
  logic          phase_last;
  logic          line_done;
  logic          nxt_href;

  // NOTE: every variable gets a default at the top so no path through the block infers a latch.
  always_comb begin
    eol        = (h_cnt == HW'(L - 1));
    h_nxt      = (state == ST_IDLE || eol) ? '0 : h_cnt + HW'(1);
    phase_last = 1'b0;
    case (state)
      ST_VSYNC:  phase_last = (v_cnt == VW'(VSYNC_LINES - 1));
      ST_VBACK:  phase_last = (v_cnt == VW'(V_BACK - 1));
      ST_ACTIVE: phase_last = (v_cnt == VW'(V_ACT - 1));
      ST_VFRONT: phase_last = (v_cnt == VW'(V_FRONT - 1));
      default:   phase_last = 1'b0;
    endcase
    line_done = eol && phase_last;
    // href in the coming cycle: any active line, including the first one entered from VBACK
    nxt_href  = ((state == ST_ACTIVE && !line_done) || (state == ST_VBACK && line_done))
                && (h_nxt < HW'(2 * H_ACT));
    ld_byte1  = nxt_href && !h_nxt[0];
    ld_byte2  = nxt_href && h_nxt[0];
  end

  // NOTE: non-blocking assignments only, so every register here sees pre-edge values.
  always_ff @(posedge CAM_pclk) begin
    if (rst) begin
      state      <= ST_IDLE;
      h_cnt      <= '0;
      v_cnt      <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      h_cnt      <= h_nxt;
      href       <= nxt_href;
      frame_done <= (state == ST_VFRONT) && phase_last && (h_cnt == HW'(L - 2));
      if (eol) v_cnt <= line_done ? '0 : v_cnt + VW'(1);
      case (state)
        ST_IDLE: begin
          if (en) begin
            state <= ST_VSYNC;
            vsync <= 1'b1;
            v_cnt <= '0;
          end
        end
        ST_VSYNC: begin
          if (line_done) begin
            state <= ST_VBACK;
            vsync <= 1'b0;
          end
        end
        ST_VBACK:  if (line_done) state <= ST_ACTIVE;
        ST_ACTIVE: if (line_done) state <= ST_VFRONT;
        ST_VFRONT: begin
          // en is only looked at here, so a frame always runs to completion
          if (line_done) begin
            state <= en ? ST_VSYNC : ST_IDLE;
            vsync <= en;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cam_tx.sv
// OV7670-style camera emulator: frame timing, frame-buffer address counter and RGB444 byte mux.
// Define CAM_TX_PATTERN_EN to send an internal 8-bar colour pattern instead of RAM data.
module cam_tx
  import cam_pkg::*;
#(
  parameter int AW          = 15,
  parameter int DW          = 12,
  parameter int H_ACT       = 160,
  parameter int V_ACT       = 120,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 2,
  parameter int V_FRONT     = 2
) (
  input logic       CAM_pclk,
  input logic       rst,
  cam_tx_if.master  bus
);

  localparam int NPIX = H_ACT * V_ACT;

  logic          vsync;
  logic          href;
  logic          frame_done;
  logic          ld_byte1;
  logic          ld_byte2;
  logic [DW-1:0] pix_src;
  logic [7:0]    pix_lo_q;
  logic [7:0]    px_q;
  logic [AW-1:0] addr_q;

  cam_tx_timing #(
    .H_ACT      (H_ACT),
    .V_ACT      (V_ACT),
    .H_BLANK    (H_BLANK),
    .VSYNC_LINES(VSYNC_LINES),
    .V_BACK     (V_BACK),
    .V_FRONT    (V_FRONT)
  ) u_timing (
    .CAM_pclk  (CAM_pclk),
    .rst       (rst),
    .en        (bus.en),
    .vsync     (vsync),
    .href      (href),
    .frame_done(frame_done),
    .ld_byte1  (ld_byte1),
    .ld_byte2  (ld_byte2)
  );

`ifdef CAM_TX_PATTERN_EN
  logic [$clog2(H_ACT)-1:0] col_q;

  always_ff @(posedge CAM_pclk) begin
    if (rst) begin
      col_q <= '0;
    end else if (ld_byte1) begin
      col_q <= (col_q == $clog2(H_ACT)'(H_ACT - 1)) ? '0 : col_q + 1'b1;
    end
  end

  assign pix_src = DW'(bar_color(int'(col_q), H_ACT));
`else
  assign pix_src = bus.RAM_data_in;
`endif

  // Byte 1 goes straight from the source word; only the low byte is kept for the byte-2 cycle.
  // Advancing the address here gives the registered RAM the whole byte-2 cycle to answer.
  always_ff @(posedge CAM_pclk) begin
    if (rst) begin
      addr_q   <= '0;
      pix_lo_q <= '0;
      px_q     <= '0;
    end else if (ld_byte1) begin
      pix_lo_q <= pix_src[7:0];
      px_q     <= {BYTE1_PAD, pix_src[DW-1 -: 4]};
      addr_q   <= (addr_q == AW'(NPIX - 1)) ? '0 : addr_q + AW'(1);
    end else if (ld_byte2) begin
      px_q <= pix_lo_q;
    end else begin
      px_q <= '0;
    end
  end

  assign bus.RAM_addr_out = addr_q;
  assign bus.CAM_vsync    = vsync;
  assign bus.CAM_href     = href;
  assign bus.CAM_px_data  = px_q;
  assign bus.frame_done   = frame_done;

endmodule

// File: tb/tb_cam_tx.sv
// Bench for cam_tx at default geometry: checkpoint table against hand values, a per-cycle
// frame model, a byte-pair capture of the whole frame, and reset/enable corner sequences.
module tb_cam_tx;

  localparam int AW       = 15;
  localparam int DW       = 12;
  localparam int H_ACT    = 160;
  localparam int V_ACT    = 120;
  localparam int L        = 336;
  localparam int NPIX     = H_ACT * V_ACT;
  localparam int VS_END   = 1008;
  localparam int FIRST_HR = 1680;
  localparam int ACT_END  = 42000;
  localparam int FRAME    = 42672;
  localparam int N_VEC    = 18;

  typedef struct {
    int          cyc;
    logic        vs;
    logic        hr;
    logic [7:0]  px;
    logic        fd;
    logic [14:0] addr;
  } vec_t;

  logic CAM_pclk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t vecs [N_VEC];

  cam_tx_if #(.AW(AW), .DW(DW)) bus ();

  cam_tx #(.AW(AW), .DW(DW)) dut (
    .CAM_pclk(CAM_pclk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 CAM_pclk = ~CAM_pclk;

  // Registered frame buffer whose word at each address is the address's low 12 bits
  always @(posedge CAM_pclk) bus.RAM_data_in <= bus.RAM_addr_out[11:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".vsync"}, 32'(bus.CAM_vsync), 0);
    check({tag, ".href"},  32'(bus.CAM_href), 0);
    check({tag, ".px"},    32'(bus.CAM_px_data), 0);
    check({tag, ".fdone"}, 32'(bus.frame_done), 0);
    check({tag, ".addr"},  32'(bus.RAM_addr_out), 0);
  endtask

  initial begin
    int          vi;
    int          idle_err, vs_err, hr_err, px_err, fd_err, addr_err, cap_err, post_err;
    int          n_cap, n_pulse, n_fd;
    logic        prev_hr, cap_phase;
    logic [7:0]  cap_hi;
    logic        e_vs, e_hr, e_fd;
    logic [7:0]  e_px;
    logic [14:0] e_addr;
    logic [11:0] p;
    int          rel, line, pos, pix;

    //          cyc    vs    hr    px     fd    addr
    vecs[0]  = '{0,     1'b1, 1'b0, 8'h00, 1'b0, 15'd0};
    vecs[1]  = '{1007,  1'b1, 1'b0, 8'h00, 1'b0, 15'd0};
    vecs[2]  = '{1008,  1'b0, 1'b0, 8'h00, 1'b0, 15'd0};
    vecs[3]  = '{1679,  1'b0, 1'b0, 8'h00, 1'b0, 15'd0};
    vecs[4]  = '{1680,  1'b0, 1'b1, 8'h00, 1'b0, 15'd1};
    vecs[5]  = '{1681,  1'b0, 1'b1, 8'h00, 1'b0, 15'd1};
    vecs[6]  = '{1683,  1'b0, 1'b1, 8'h01, 1'b0, 15'd2};
    vecs[7]  = '{1999,  1'b0, 1'b1, 8'h9F, 1'b0, 15'd160};
    vecs[8]  = '{2000,  1'b0, 1'b0, 8'h00, 1'b0, 15'd160};
    vecs[9]  = '{2018,  1'b0, 1'b1, 8'h00, 1'b0, 15'd162};
    vecs[10] = '{2019,  1'b0, 1'b1, 8'hA1, 1'b0, 15'd162};
    vecs[11] = '{41981, 1'b0, 1'b1, 8'hFE, 1'b0, 15'd19199};
    vecs[12] = '{41982, 1'b0, 1'b1, 8'h0A, 1'b0, 15'd0};
    vecs[13] = '{41983, 1'b0, 1'b1, 8'hFF, 1'b0, 15'd0};
    vecs[14] = '{41984, 1'b0, 1'b0, 8'h00, 1'b0, 15'd0};
    vecs[15] = '{42670, 1'b0, 1'b0, 8'h00, 1'b0, 15'd0};
    vecs[16] = '{42671, 1'b0, 1'b0, 8'h00, 1'b1, 15'd0};
    vecs[17] = '{42672, 1'b0, 1'b0, 8'h00, 1'b0, 15'd0};

    // Reset hold with en high: reset must win
    rst    = 1'b1;
    bus.en = 1'b1;
    repeat (5) @(posedge CAM_pclk);
    @(negedge CAM_pclk);
    check_all_zero("reset");

    // Released with en low: nothing moves for 1000 cycles
    bus.en   = 1'b0;
    rst      = 1'b0;
    idle_err = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CAM_pclk);
      if (bus.CAM_vsync || bus.CAM_href || bus.CAM_px_data != 0 || bus.frame_done
          || bus.RAM_addr_out != 0) idle_err++;
    end
    check("idle_1000_outputs", idle_err, 0);

    // One full frame from the en edge (cycle 0); en drops at cycle 20000 so the block returns to IDLE
    bus.en    = 1'b1;
    vi        = 0;
    vs_err    = 0; hr_err = 0; px_err = 0; fd_err = 0; addr_err = 0; cap_err = 0; post_err = 0;
    n_cap     = 0; n_pulse = 0; n_fd = 0;
    prev_hr   = 1'b0;
    cap_phase = 1'b0;
    cap_hi    = '0;
    for (int c = 0; c < FRAME + 20; c++) begin
      @(negedge CAM_pclk);

      if (vi < N_VEC && vecs[vi].cyc == c) begin
        check($sformatf("vec%0d@%0d.vsync", vi, c), 32'(bus.CAM_vsync), 32'(vecs[vi].vs));
        check($sformatf("vec%0d@%0d.href", vi, c), 32'(bus.CAM_href), 32'(vecs[vi].hr));
        check($sformatf("vec%0d@%0d.px", vi, c), 32'(bus.CAM_px_data), 32'(vecs[vi].px));
        check($sformatf("vec%0d@%0d.fdone", vi, c), 32'(bus.frame_done), 32'(vecs[vi].fd));
        check($sformatf("vec%0d@%0d.addr", vi, c), 32'(bus.RAM_addr_out), 32'(vecs[vi].addr));
        vi++;
      end

      e_vs = (c < VS_END); e_hr = 1'b0; e_px = '0; e_fd = (c == FRAME - 1); e_addr = '0;
      if (c >= FIRST_HR && c < ACT_END) begin
        rel  = c - FIRST_HR;
        line = rel / L;
        pos  = rel % L;
        if (pos < 2 * H_ACT) begin
          pix    = line * H_ACT + pos / 2;
          p      = 12'(pix);
          e_hr   = 1'b1;
          e_px   = (pos % 2 == 0) ? {4'h0, p[11:8]} : p[7:0];
          e_addr = 15'((pix + 1) % NPIX);
        end else begin
          e_addr = 15'(((line + 1) * H_ACT) % NPIX);
        end
      end

      if (c < FRAME) begin
        if (bus.CAM_vsync !== e_vs) vs_err++;
        if (bus.CAM_href !== e_hr) hr_err++;
        if (bus.CAM_px_data !== e_px) px_err++;
        if (bus.frame_done !== e_fd) fd_err++;
        if (bus.RAM_addr_out !== e_addr) addr_err++;
      end else begin
        if (bus.CAM_vsync || bus.CAM_href || bus.CAM_px_data != 0 || bus.frame_done
            || bus.RAM_addr_out != 0) post_err++;
      end

      if (bus.frame_done) n_fd++;
      if (bus.CAM_href && !prev_hr) n_pulse++;
      prev_hr = bus.CAM_href;

      // Capture side: rebuild 12-bit words from byte pairs and compare to the source buffer
      if (bus.CAM_href) begin
        if (!cap_phase) begin
          cap_hi    = bus.CAM_px_data;
          cap_phase = 1'b1;
        end else begin
          if (cap_hi[7:4] != 4'h0 || {cap_hi[3:0], bus.CAM_px_data} !== 12'(n_cap)) cap_err++;
          n_cap++;
          cap_phase = 1'b0;
        end
      end

      if (c == 20000) bus.en = 1'b0;
    end
    check("vec_table_reached", vi, N_VEC);
    check("vsync_window_errs", vs_err, 0);
    check("href_window_errs", hr_err, 0);
    check("px_byte_errs", px_err, 0);
    check("frame_done_errs", fd_err, 0);
    check("addr_errs", addr_err, 0);
    check("href_pulse_count", n_pulse, V_ACT);
    check("frame_done_count", n_fd, 1);
    check("captured_words", n_cap, NPIX);
    check("capture_vs_source_errs", cap_err, 0);
    check("idle_after_en_drop_errs", post_err, 0);

    // Mid-href reset: start a frame, reset on cycle 1700, restart with en held high
    bus.en = 1'b1;
    for (int c = 0; c <= 1700; c++) begin
      @(negedge CAM_pclk);
      if (c == 0) check("restart0.vsync", 32'(bus.CAM_vsync), 1);
    end
    check("pre_rst.href", 32'(bus.CAM_href), 1);
    rst = 1'b1;
    @(negedge CAM_pclk);
    check_all_zero("mid_href_rst");
    rst = 1'b0;
    @(negedge CAM_pclk);
    check("after_rst.vsync", 32'(bus.CAM_vsync), 1);
    check("after_rst.href", 32'(bus.CAM_href), 0);
    check("after_rst.addr", 32'(bus.RAM_addr_out), 0);
    for (int c = 1; c <= FIRST_HR + 1; c++) begin
      @(negedge CAM_pclk);
      if (c == FIRST_HR) begin
        check("after_rst.href1680", 32'(bus.CAM_href), 1);
        check("after_rst.px1680", 32'(bus.CAM_px_data), 0);
        check("after_rst.addr1680", 32'(bus.RAM_addr_out), 1);
      end
    end
    check("after_rst.addr1681", 32'(bus.RAM_addr_out), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_tx.md
# cam_tx

Camera-side transmitter generating OV7670-style frame timing (CAM_vsync, CAM_href, 8-bit CAM_px_data) in the CAM_pclk domain. Each frame is sourced from a synchronous-read frame buffer in 12-bit RGB444. The block serves as the camera emulator for bench and board bring-up of the capture path. Its byte stream is exactly what the capture logic consumes: two bytes per pixel, the high nibble of byte 1 zero.

## Interface
- AW, 15, frame-buffer address width
- DW, 12, pixel word width (RGB444)
- H_ACT, 160, active pixels per line
- V_ACT, 120, active lines per frame
- H_BLANK, 16, href-low cycles per line
- VSYNC_LINES, 3, line periods with vsync high
- V_BACK, 2, blank lines after vsync
- V_FRONT, 2, blank lines after last active line
- CAM_pclk  in  1  pixel clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- en  in  1  frame enable, sampled at frame boundaries
- RAM_addr_out  out  AW  frame-buffer read address
- RAM_data_in  in  DW  read data, valid one cycle after address (registered RAM)
- CAM_vsync  out  1  frame sync, active high
- CAM_href  out  1  line valid, active high
- CAM_px_data  out  8  pixel byte
- frame_done  out  1  one-cycle pulse on the last cycle of a frame

## Operation
- States: IDLE, VSYNC, VBACK, ACTIVE, VFRONT. Line period L = 2*H_ACT + H_BLANK (336 at defaults).
- IDLE: all outputs 0. Sampled en=1 → VSYNC; CAM_vsync=1 from that edge.
- VSYNC: vsync high for VSYNC_LINES*L cycles, then VBACK (V_BACK*L cycles, vsync/href low).
- ACTIVE: V_ACT lines; each line is href high for 2*H_ACT cycles, then low for H_BLANK.
- After the last active line: VFRONT for V_FRONT*L cycles. frame_done pulses on its final cycle.
- At frame end: en=1 → VSYNC with no gap; en=0 → IDLE. en is ignored mid-frame.
- Byte order per pixel: byte1 = {4'b0000, pix[11:8]}, byte2 = pix[7:0]. CAM_px_data = 0 whenever href is low.
- Pixel register loads RAM_data_in at the edge launching byte1. RAM_addr_out increments at that same edge.
- This gives the RAM a full byte2 cycle to return the next pixel.
- RAM_addr_out = 0 at frame start and is held through all blanking.
- RAM_addr_out wraps to 0 after H_ACT*V_ACT-1 (19199). Counter is AW bits; no other wrap.

## Timing
- Reset: state IDLE; CAM_vsync, CAM_href, CAM_px_data, frame_done, RAM_addr_out all 0 at the edge rst is sampled high.
- rst mid-frame aborts immediately. Restart takes one edge with en=1.
- Counted from the vsync rising edge (cycle 0):
  - vsync falls at cycle VSYNC_LINES*L (1008)
  - first href rise at cycle (VSYNC_LINES+V_BACK)*L (1680)
  - frame length (VSYNC_LINES+V_BACK+V_ACT+V_FRONT)*L (42672); frame_done at cycle 42671
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- CAM_TX_PATTERN_EN defined: pixel register loads an internal 8-bar colour pattern instead of RAM_data_in.
  - Bar index = col / (H_ACT/8).
  - Colours FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - RAM_addr_out is still driven identically.
- Undefined: pixels come from RAM_data_in only.

## Structure
- Package cam_pkg: state enum, RGB444 byte-packing constants, bar colour table.
- Sub-module cam_tx_timing: pixel/line counters and state machine, emitting vsync, href, byte phase and frame_done.
- Top-level cam_tx adds the address counter, pixel register and byte mux.

## Test plan
- Reset hold, then release with en=0 → all outputs stay 0 for 1000 cycles.
- en=1, defaults: vsync high cycles 0–1007; 120 href pulses of 320 cycles each; first at 1680; frame_done at 42671 only.
- RAM model returning data = addr[11:0]:
  - pixel 0 → bytes 0x00,0x00
  - pixel 161 → bytes 0x00,0xA1
  - pixel 19199 → 0x0A,0xFF; RAM_addr_out then 0
- Loopback into the capture block: captured buffer equals source buffer for all 19200 words.
- en dropped at cycle 20000 → frame completes, frame_done fires, then IDLE with vsync low.
- rst pulsed mid-href → all outputs 0 next edge; next frame restarts at VSYNC with address 0.
- CAM_TX_PATTERN_EN: col 0 → 0x0F,0xFF; col 20 → 0x0F,0xF0; col 159 → 0x00,0x00.
